// File: rtl/priority_encoder_3_bit_seq_pkg.sv
// priority_encoder_3_bit_seq_pkg
// Shared constants and selection helpers for the registered 8-to-3 request
// encoder.
//   N        : number of request lines (always 2**W)
//   W        : code width in bits
//   onehot   : expands a W-bit code to an N-bit one-hot mask
//   prio_sel : fixed priority; the highest set index wins; returns 0 for an empty vector
//   rr_sel   : round-robin; searches upward from ptr+1 with wrap-around and
//              returns 0 for an empty vector
package priority_encoder_3_bit_seq_pkg;

  localparam int unsigned N = 8;
  localparam int unsigned W = 3;

  function automatic logic [N-1:0] onehot(input logic [W-1:0] code);
    logic [N-1:0] m;
    m = '0;
    m[code] = 1'b1;
    return m;
  endfunction

  function automatic logic [W-1:0] prio_sel(input logic [N-1:0] vec);
    logic [W-1:0] s;
    s = '0;
    // Ascending scan, so the last hit is the highest set index.
    for (int unsigned i = 0; i < N; i++) begin
      if (vec[i]) s = W'(i);
    end
    return s;
  endfunction

  function automatic logic [W-1:0] rr_sel(input logic [N-1:0] vec,
                                          input logic [W-1:0] ptr);
    logic [W-1:0] s;
    logic [W-1:0] idx;
    logic         found;
    s     = '0;
    found = 1'b0;
    // N == 2**W, so a W-bit add wraps from index N-1 to index 0.
    // The scan visits ptr itself last.
    for (int unsigned i = 1; i <= N; i++) begin
      idx = ptr + W'(i);
      if (!found && vec[idx]) begin
        s     = idx;
        found = 1'b1;
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/priority_encoder_3_bit_seq_prio_sel_comb.sv
// prio_sel_comb
// A purely combinational N-to-W winner selector.
// The build macro PRIORITY_ENCODER_ROUND_ROBIN_EN chooses the mode:
//   undefined : fixed priority; the highest set index wins
//   defined   : round-robin; the search starts at ptr+1
// Ports:
//   vec : input  N  candidate request vector
//   ptr : input  W  last served index (present only in round-robin builds)
//   sel : output W  index of the winning line; 0 when vec is empty
module prio_sel_comb
  import priority_encoder_3_bit_seq_pkg::*;
(
  input  logic [N-1:0] vec,
`ifdef PRIORITY_ENCODER_ROUND_ROBIN_EN
  input  logic [W-1:0] ptr,
`endif
  output logic [W-1:0] sel
);

  always_comb begin
`ifdef PRIORITY_ENCODER_ROUND_ROBIN_EN
    sel = rr_sel(vec, ptr);
`else
    sel = prio_sel(vec);
`endif
  end

endmodule

// File: rtl/priority_encoder_3_bit_seq.sv
// priority_encoder_3_bit_seq
// A registered 8-to-3 request encoder with a valid/ack handshake.
// The design latches request lines into a pending register. It presents the
// winning index on A and holds it until the consumer acks it. The ack then
// clears the served request.
// The build macro PRIORITY_ENCODER_ROUND_ROBIN_EN selects round-robin
// arbitration. When the macro is undefined, fixed priority applies and the
// highest index wins.
// Ports:
//   clk : input  1  rising-edge clock
//   rst : input  1  synchronous active-high reset
//   R   : input  N  request lines, sampled while E=1
//   E   : input  1  request enable; pending requests and acks still proceed when E=0
//   ack : input  1  consumer accepts A; takes effect only when V=1
//   A   : output W  registered index of the selected pending request
//   V   : output 1  registered flag; at least one request is pending
//   ovf : output 1  registered one-cycle pulse; a request hit a line that was
//                   already pending and is not being cleared
module priority_encoder_3_bit_seq
  import priority_encoder_3_bit_seq_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] R,
  input  logic         E,
  input  logic         ack,
  output logic [W-1:0] A,
  output logic         V,
  output logic         ovf
);

  logic [N-1:0] pend;
  logic [N-1:0] pend_n;
  logic [N-1:0] clr;
  logic [N-1:0] set;
  logic [W-1:0] sel_n;
  logic         ovf_n;
  logic         ack_eff;

`ifdef PRIORITY_ENCODER_ROUND_ROBIN_EN
  logic [W-1:0] ptr;
`endif

  always_comb begin
    ack_eff = ack && V;
    clr     = ack_eff ? onehot(A) : '0;
    set     = E ? R : '0;
    // A set applied after the clear keeps a bit that is cleared and
    // re-requested in the same cycle pending.
    pend_n  = (pend & ~clr) | set;
    ovf_n   = |(set & pend & ~clr);
  end

  prio_sel_comb u_sel (
    .vec (pend_n),
`ifdef PRIORITY_ENCODER_ROUND_ROBIN_EN
    .ptr (ptr),
`endif
    .sel (sel_n)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
      A    <= '0;
      V    <= 1'b0;
      ovf  <= 1'b0;
`ifdef PRIORITY_ENCODER_ROUND_ROBIN_EN
      ptr  <= W'(N - 1);
`endif
    end else begin
      pend <= pend_n;
      A    <= sel_n;
      V    <= |pend_n;
      ovf  <= ovf_n;
`ifdef PRIORITY_ENCODER_ROUND_ROBIN_EN
      if (ack_eff) ptr <= A;
`endif
    end
  end

endmodule

// File: tb/tb_priority_encoder_3_bit_seq.sv
module tb_priority_encoder_3_bit_seq;

  logic       clk;
  logic       rst;
  logic [7:0] R;
  logic       E;
  logic       ack;
  logic [2:0] A;
  logic       V;
  logic       ovf;

  int errors = 0;
  int checks = 0;

  priority_encoder_3_bit_seq dut (
    .clk (clk),
    .rst (rst),
    .R   (R),
    .E   (E),
    .ack (ack),
    .A   (A),
    .V   (V),
    .ovf (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; R = '0; E = 1'b0; ack = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [2:0] exp_a;
`ifdef PRIORITY_ENCODER_ROUND_ROBIN_EN
    exp_a = 3'd0;
`else
    exp_a = 3'd7;
`endif
    rst = 1'b1; R = 8'hFF; E = 1'b1; ack = 1'b0;
    tick();
    checks++; if (A !== 3'd0) begin errors++; $display("FAIL reset_A: got %0d want 0", A); end
    checks++; if (V !== 1'b0) begin errors++; $display("FAIL reset_V: got %0b want 0", V); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b want 0", ovf); end
    rst = 1'b0;
    tick();
    R = '0;
    checks++; if (V !== 1'b1) begin errors++; $display("FAIL post_reset_V: got %0b want 1", V); end
    checks++; if (A !== exp_a) begin errors++; $display("FAIL post_reset_A: got %0d want %0d", A, exp_a); end
    // Reset in the middle of a handshake discards all pending requests.
    rst = 1'b1; ack = 1'b1;
    tick();
    rst = 1'b0; ack = 1'b0;
    tick();
    checks++; if (V !== 1'b0) begin errors++; $display("FAIL reset_discard_V: got %0b want 0", V); end
  endtask

  task automatic test_single();
    do_reset();
    R = 8'h10; E = 1'b1;
    tick();
    R = '0;
    checks++; if (A !== 3'd4 || V !== 1'b1) begin errors++; $display("FAIL single_first: got A=%0d V=%0b want A=4 V=1", A, V); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (A !== 3'd4 || V !== 1'b1) begin errors++; $display("FAIL single_hold%0d: got A=%0d V=%0b want A=4 V=1", i, A, V); end
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if (V !== 1'b0 || A !== 3'd0) begin errors++; $display("FAIL single_ack: got A=%0d V=%0b want A=0 V=0", A, V); end
    // An ack while V=0 has no effect.
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if (V !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL idle_ack: got V=%0b ovf=%0b want 0 0", V, ovf); end
  endtask

  task automatic test_drain();
    logic [2:0] exp_seq [4];
`ifdef PRIORITY_ENCODER_ROUND_ROBIN_EN
    exp_seq = '{3'd0, 3'd2, 3'd5, 3'd7};
`else
    exp_seq = '{3'd7, 3'd5, 3'd2, 3'd0};
`endif
    do_reset();
    R = 8'hA5; E = 1'b1;
    tick();
    R = '0; ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (A !== exp_seq[i] || V !== 1'b1) begin errors++; $display("FAIL drain%0d: got A=%0d V=%0b want A=%0d V=1", i, A, V, exp_seq[i]); end
      tick();
    end
    ack = 1'b0;
    checks++; if (V !== 1'b0) begin errors++; $display("FAIL drain_empty: got V=%0b want 0", V); end
  endtask

  task automatic test_enable_ovf();
    do_reset();
    R = 8'h08; E = 1'b0;
    tick();
    tick();
    checks++; if (V !== 1'b0) begin errors++; $display("FAIL enable_off: got V=%0b want 0", V); end
    E = 1'b1;
    tick();
    checks++; if (V !== 1'b1 || A !== 3'd3 || ovf !== 1'b0) begin errors++; $display("FAIL enable_on: got A=%0d V=%0b ovf=%0b want 3 1 0", A, V, ovf); end
    tick();
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %0b want 1", ovf); end
    R = '0;
    tick();
    checks++; if (ovf !== 1'b0 || A !== 3'd3 || V !== 1'b1) begin errors++; $display("FAIL ovf_clear: got A=%0d V=%0b ovf=%0b want 3 1 0", A, V, ovf); end
  endtask

  // Continues from the state left by test_enable_ovf (A=3, V=1).
  task automatic test_collision();
    ack = 1'b1; R = 8'h08; E = 1'b1;
    tick();
    checks++; if (V !== 1'b1 || A !== 3'd3 || ovf !== 1'b0) begin errors++; $display("FAIL collision: got A=%0d V=%0b ovf=%0b want 3 1 0", A, V, ovf); end
    R = '0;
    tick();
    ack = 1'b0;
    checks++; if (V !== 1'b0) begin errors++; $display("FAIL collision_drain: got V=%0b want 0", V); end
  endtask

  task automatic test_preempt();
    logic [2:0] exp_a;
`ifdef PRIORITY_ENCODER_ROUND_ROBIN_EN
    exp_a = 3'd2;
`else
    exp_a = 3'd6;
`endif
    do_reset();
    R = 8'h04; E = 1'b1;
    tick();
    R = 8'h40;
    tick();
    R = '0;
    checks++; if (A !== exp_a || V !== 1'b1) begin errors++; $display("FAIL preempt: got A=%0d V=%0b want A=%0d V=1", A, V, exp_a); end
  endtask

  task automatic test_all_lines();
    logic [2:0] exp_a;
    do_reset();
    R = 8'hFF; E = 1'b1;
    tick();
    R = '0; ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
`ifdef PRIORITY_ENCODER_ROUND_ROBIN_EN
      exp_a = 3'(i);
`else
      exp_a = 3'(7 - i);
`endif
      checks++; if (A !== exp_a || V !== 1'b1) begin errors++; $display("FAIL all_lines%0d: got A=%0d V=%0b want A=%0d V=1", i, A, V, exp_a); end
      tick();
    end
    ack = 1'b0;
    checks++; if (V !== 1'b0) begin errors++; $display("FAIL all_lines_empty: got V=%0b want 0", V); end
  endtask

`ifdef PRIORITY_ENCODER_ROUND_ROBIN_EN
  task automatic test_rr_rerequest();
    do_reset();
    R = 8'h01; E = 1'b1;
    tick();
    R = '0;
    checks++; if (A !== 3'd0 || V !== 1'b1) begin errors++; $display("FAIL rr_first: got A=%0d V=%0b want 0 1", A, V); end
    ack = 1'b1;
    tick();
    ack = 1'b0; R = 8'h81;
    tick();
    R = '0;
    checks++; if (A !== 3'd7) begin errors++; $display("FAIL rr_seven_first: got %0d want 7", A); end
    ack = 1'b1;
    tick();
    checks++; if (A !== 3'd0 || V !== 1'b1) begin errors++; $display("FAIL rr_zero_next: got A=%0d V=%0b want 0 1", A, V); end
    tick();
    ack = 1'b0;
    checks++; if (V !== 1'b0) begin errors++; $display("FAIL rr_empty: got V=%0b want 0", V); end
  endtask
`endif

  initial begin
    rst = 1'b1; R = '0; E = 1'b0; ack = 1'b0;
    test_reset();
    test_single();
    test_drain();
    test_enable_ovf();
    test_collision();
    test_preempt();
    test_all_lines();
`ifdef PRIORITY_ENCODER_ROUND_ROBIN_EN
    test_rr_rerequest();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
